// File: rtl/pipe_ex.sv
// rtl/pipe_ex.sv - execute stage: ALU, branch/jump resolution, serial shifter, single output slot
module pipe_ex #(
    parameter int REG_SZ       = 32,
    parameter int ALUOP_L      = 5,
    parameter bit SERIAL_SHIFT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        pc_in,
    input  logic [ALUOP_L-1:0] alu_op,
    input  logic               alu_c,
    input  logic [4:0]         rd,
    input  logic [REG_SZ-1:0]  opr1,
    input  logic [REG_SZ-1:0]  opr2,
    input  logic [REG_SZ-1:0]  val,
    input  logic               jp_e,
    input  logic               br_e,
    input  logic               wb_e,
    input  logic [1:0]         rw_e,
    input  logic [1:0]         rw_len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         out_rd,
    output logic               out_wb_e,
    output logic [1:0]         out_rw_e,
    output logic [1:0]         out_rw_len,
    output logic [REG_SZ-1:0]  out_result,
    output logic [REG_SZ-1:0]  out_data,
    output logic               redirect,
    output logic [31:0]        redirect_pc,
    output logic [4:0]         EX_fwd_idx,
    output logic [31:0]        EX_fwd_val,
    output logic               busy
);
    localparam logic [ALUOP_L-1:0] OP_ADD  = ALUOP_L'(0);
    localparam logic [ALUOP_L-1:0] OP_SUB  = ALUOP_L'(1);
    localparam logic [ALUOP_L-1:0] OP_XOR  = ALUOP_L'(2);
    localparam logic [ALUOP_L-1:0] OP_OR   = ALUOP_L'(3);
    localparam logic [ALUOP_L-1:0] OP_AND  = ALUOP_L'(4);
    localparam logic [ALUOP_L-1:0] OP_SLT  = ALUOP_L'(5);
    localparam logic [ALUOP_L-1:0] OP_SLTU = ALUOP_L'(6);
    localparam logic [ALUOP_L-1:0] OP_SEQ  = ALUOP_L'(7);
    localparam logic [ALUOP_L-1:0] OP_PASS = ALUOP_L'(8);
    localparam logic [ALUOP_L-1:0] OP_SLL  = ALUOP_L'(9);
    localparam logic [ALUOP_L-1:0] OP_SRL  = ALUOP_L'(10);
    localparam logic [ALUOP_L-1:0] OP_SRA  = ALUOP_L'(11);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [4:0]         count;
    logic [REG_SZ-1:0]  sh_val;
    logic [1:0]         sh_kind;
    logic [4:0]         sh_rd;
    logic               sh_wb;
    logic [1:0]         sh_len;

    logic [4:0]         shamt;
    logic               is_shift_op;
    logic               start_shift;
    logic [REG_SZ-1:0]  alu_res;
    logic [REG_SZ-1:0]  sum;
    logic [31:0]        link;
    logic [31:0]        jmp_tgt;
    logic               cmp;
    logic               taken;
    logic [31:0]        tgt;
    logic [REG_SZ-1:0]  res;
    logic [REG_SZ-1:0]  sh_next;
    logic               slot_free;
    logic               accept;

    assign shamt       = opr2[4:0];
    assign is_shift_op = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
    assign start_shift = SERIAL_SHIFT && is_shift_op && (shamt != 5'd0)
                         && !jp_e && !br_e && (rw_e == 2'b00);

    always_comb begin
        alu_res = '0;
        case (alu_op)
            OP_ADD:  alu_res = opr1 + opr2;
            OP_SUB:  alu_res = opr1 - opr2;
            OP_XOR:  alu_res = opr1 ^ opr2;
            OP_OR:   alu_res = opr1 | opr2;
            OP_AND:  alu_res = opr1 & opr2;
            OP_SLT:  alu_res = REG_SZ'($signed(opr1) < $signed(opr2));
            OP_SLTU: alu_res = REG_SZ'(opr1 < opr2);
            OP_SEQ:  alu_res = REG_SZ'(opr1 == opr2);
            OP_PASS: alu_res = opr1;
            OP_SLL:  alu_res = opr1 << shamt;
            OP_SRL:  alu_res = opr1 >> shamt;
            OP_SRA:  alu_res = $signed(opr1) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    // Branch target and jump link share one adder: both are pc_in + val.
    assign sum     = opr1 + opr2;
    assign link    = pc_in + val[31:0];
    assign jmp_tgt = sum[31:0] & 32'hFFFF_FFFE;
    assign cmp     = alu_res[0] ^ alu_c;
    assign taken   = jp_e || (br_e && cmp);
    assign tgt     = jp_e ? jmp_tgt : link;

    always_comb begin
        res = alu_res;
        if (jp_e)
            res = REG_SZ'(link);
        else if (br_e)
            res = REG_SZ'(cmp);
        else if (rw_e != 2'b00)
            res = sum;
    end

    always_comb begin
        sh_next = sh_val;
        case (sh_kind)
            2'd0:    sh_next = {sh_val[REG_SZ-2:0], 1'b0};
            2'd1:    sh_next = {1'b0, sh_val[REG_SZ-1:1]};
            default: sh_next = {sh_val[REG_SZ-1], sh_val[REG_SZ-1:1]};
        endcase
    end

    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == IDLE) && slot_free;
    assign accept    = in_valid && in_ready;

    // Loads are not forwarded: their value only exists after the memory stage.
    assign EX_fwd_idx = (out_valid && out_wb_e && !out_rw_e[1] && out_rd != 5'd0) ? out_rd : 5'd0;
    assign EX_fwd_val = out_result[31:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            count       <= '0;
            sh_val      <= '0;
            sh_kind     <= '0;
            sh_rd       <= '0;
            sh_wb       <= 1'b0;
            sh_len      <= '0;
            busy        <= 1'b0;
            out_valid   <= 1'b0;
            out_rd      <= '0;
            out_wb_e    <= 1'b0;
            out_rw_e    <= '0;
            out_rw_len  <= '0;
            out_result  <= '0;
            out_data    <= '0;
            redirect    <= 1'b0;
            redirect_pc <= '0;
        end else begin
            redirect <= 1'b0;
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (start_shift) begin
                            state   <= SHIFT;
                            busy    <= 1'b1;
                            count   <= shamt;
                            sh_val  <= opr1;
                            sh_kind <= (alu_op == OP_SLL) ? 2'd0 : (alu_op == OP_SRL) ? 2'd1 : 2'd2;
                            sh_rd   <= rd;
                            sh_wb   <= wb_e;
                            sh_len  <= rw_len;
                        end else begin
                            out_valid  <= 1'b1;
                            out_rd     <= rd;
                            out_wb_e   <= wb_e && !br_e;
                            out_rw_e   <= rw_e;
                            out_rw_len <= rw_len;
                            out_result <= res;
                            out_data   <= val;
                            redirect   <= taken;
                            if (taken)
                                redirect_pc <= tgt;
                        end
                    end
                end
                SHIFT: begin
                    // The last step is held back until the slot can take it.
                    if (count == 5'd1) begin
                        if (slot_free) begin
                            out_valid  <= 1'b1;
                            out_rd     <= sh_rd;
                            out_wb_e   <= sh_wb;
                            out_rw_e   <= 2'b00;
                            out_rw_len <= sh_len;
                            out_result <= sh_next;
                            out_data   <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end
                    end else begin
                        sh_val <= sh_next;
                        count  <= count - 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/pipe_ex.md
Name: pipe_ex

Overview:
- Execute stage. Consumes the decoded bundle from the decode stage: alu_op, alu_c, opr1/opr2/val, pc, rd, and the jp/br/wb/rw controls.
- Computes the ALU result, the memory address and store data, the link value, and branch/jump resolution.
- Registers the result into a single output slot for the memory-access stage.
- Drives the EX forwarding pair back to decode and drives the redirect to fetch.

Parameters:
- REG_SZ, 32, datapath width.
- ALUOP_L, 5, alu_op width; codes per alu_opcode.v macros.
- SERIAL_SHIFT, 1: 1 = SLL/SRL/SRA shift by one bit per cycle; 0 = single-cycle barrel shift.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  decode bundle valid.
- in_ready  out  1  bundle accepted this cycle when in_valid&in_ready.
- pc_in  in  32  instruction pc.
- alu_op  in  ALUOP_L  ALU operation.
- alu_c  in  1  invert compare result (BNE/BGE/BGEU).
- rd  in  5  destination register.
- opr1, opr2, val  in  REG_SZ  operands; val = branch offset, link increment, or store data.
- jp_e, br_e, wb_e  in  1  jump / branch / writeback enables.
- rw_e, rw_len  in  2  memory op (00 none, 01 store, 10 load signed, 11 load unsigned) and size.
- out_valid  out  1  output slot full.
- out_ready  in  1  memory stage accepts slot.
- out_rd  out  5  registered rd.
- out_wb_e  out  1  registered wb_e.
- out_rw_e, out_rw_len  out  2  registered memory controls.
- out_result  out  REG_SZ  ALU result, link value, or memory address.
- out_data  out  REG_SZ  store data.
- redirect  out  1  one-cycle pulse: taken branch or jump.
- redirect_pc  out  32  target pc, valid with redirect.
- EX_fwd_idx  out  5  forwarding register index (0 = none).
- EX_fwd_val  out  32  forwarding value.
- busy  out  1  serial shift in progress.

Behaviour:
- Reset (rst low, async): out_valid=0, redirect=0, busy=0, all out_* and redirect_pc=0, EX_fwd_idx=0, EX_fwd_val=0, state=IDLE.
- A reset asserted mid-shift aborts the shift; nothing is emitted.
- in_ready = (state==IDLE) && (!out_valid || out_ready).
- The output slot holds its contents while out_valid && !out_ready.
- Accept rule: on an accepted non-shift op (or any op when SERIAL_SHIFT=0), the slot loads at the next edge. Latency is 1 cycle.
- ALU: ADD, SUB, XOR, OR, AND, SLT (signed), SLTU, SEQ (1 if equal), PASS (=opr1). Shift amount = opr2[4:0].
- Compare result = ALU bit0 XOR alu_c.
- br_e: taken = compare result; redirect_pc = pc_in + val; out_result = compare result; out_wb_e forced 0.
- jp_e: target = opr1+opr2; bit0 of the target is cleared for all jumps; out_result = pc_in + val (link); redirect always.
- rw_e!=0: out_result = opr1+opr2 (address); out_data = val.
- redirect and redirect_pc are registered and pulse for exactly the cycle the slot becomes valid with that instruction. They are not re-asserted while the slot stalls.
- FSM (SERIAL_SHIFT=1): IDLE -> SHIFT on acceptance of SLL/SRL/SRA with shamt!=0.
  - Latch operand and count=shamt; busy=1.
  - Each cycle, shift by 1 (SRA replicates bit31) and decrement count.
  - At count==1, the final shift occurs and the result loads the slot. Return to IDLE, busy=0.
  - Total latency = shamt cycles; shamt=0 takes the normal 1-cycle path.
  - SHIFT never advances while out_valid && !out_ready at completion; it waits in SHIFT with count==1.
- Forwarding: EX_fwd_idx = out_rd when out_valid && out_wb_e && out_rw_e[1]==0 && out_rd!=0, else 0. EX_fwd_val = out_result.
  - Loads never forward from this stage.
- Arithmetic: all adds are modulo 2^32; wrap is silent.
- Simultaneous out_ready and new acceptance in the same cycle: the slot is replaced without a bubble.

Test Plan:
- Reset: hold rst=0 mid-SHIFT (SRA shamt=20) -> out_valid=0, busy=0, in_ready=1 after release; no slot write.
- ADD: opr1=0xFFFFFFFF, opr2=2, rd=5, wb_e=1 -> next cycle out_result=1, EX_fwd_idx=5, EX_fwd_val=1.
- BNE: opr1=3, opr2=4, alu_op=SEQ, alu_c=1, br_e=1, pc=0x100, val=-8 -> redirect=1 for one cycle, redirect_pc=0xF8, EX_fwd_idx=0.
- JALR: opr1=0x1003, opr2=0, val=4, pc=0x40, rd=1 -> redirect_pc=0x1002, out_result=0x44.
- Serial SRA: opr1=0x80000000, opr2=4 -> busy for 4 cycles, in_ready=0 throughout, out_result=0xF8000000; shamt=0 -> 1-cycle path.
- Backpressure: out_ready=0 with slot full plus a new input -> in_ready=0, slot and EX_fwd held, redirect not repeated. out_ready=1 and in_valid=1 same cycle -> slot replaced next edge.
